pulse_peak_detector: RTL
========================

PULSE_PEAK_DETECTOR -- requirements
Module: pulse_peak_detector

Interface
REQ-001 Parameters, one per line (name, default, meaning): SIZE_FILTER_DATA, 16, sample width; THRESHOLD, 100, signed arm level; HOLDOFF_LEN, 4, dead cycles after an event; MAX_LEN, 64, maximum pulse length in samples; TS_W, 32, timestamp width; BL_SHIFT, 4, baseline averaging shift.
REQ-002 Ports, one per line (name, direction, width, meaning); clock and reset come first:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- input_data  in  SIZE_FILTER_DATA  signed shaped sample from the trapezoidal filter, one per clk
- peak_value  out  SIZE_FILTER_DATA  signed pulse amplitude
- peak_time  out  TS_W  timestamp of the maximum sample
- peak_valid  out  1  one-cycle event strobe
- peak_overflow  out  1  event was closed by MAX_LEN timeout, qualified by peak_valid
- busy  out  1  high in ARMED or HOLDOFF
- event_count  out  16  number of events emitted, wraps

Function
REQ-003 The block SHALL sample input_data on every rising clk; a free-running timestamp counter SHALL increment by 1 per clk and wrap modulo 2^TS_W.
REQ-004 The FSM SHALL have exactly three states: IDLE, ARMED, HOLDOFF.
REQ-005 IDLE->ARMED SHALL occur when the compared sample is >= THRESHOLD; that sample SHALL load max and max_time, and the length counter SHALL load 1.
REQ-006 In ARMED, a sample strictly greater than max SHALL update max and max_time; on ties the first occurrence SHALL be kept.
REQ-007 In ARMED, a sample < THRESHOLD SHALL close the event: the state goes to HOLDOFF, and peak_valid=1, peak_value=max and peak_time=max_time SHALL be registered at that same edge, with peak_overflow=0.
REQ-008 In ARMED, when the length counter reaches MAX_LEN while the sample is still >= THRESHOLD, the event SHALL close the same way with peak_overflow=1.
REQ-009 peak_valid SHALL be high for exactly one cycle per event; peak_value and peak_time SHALL hold until the next event.
REQ-010 HOLDOFF SHALL last exactly HOLDOFF_LEN cycles and ignore input, then return to IDLE; HOLDOFF_LEN=0 SHALL return to IDLE on the next edge.
REQ-011 event_count SHALL increment on each peak_valid and wrap from 65535 to 0.
REQ-012 Compare and amplitude arithmetic SHALL be signed at SIZE_FILTER_DATA+1 bits, with the result saturated to the SIZE_FILTER_DATA signed range.
REQ-013 A sample that is >= THRESHOLD during HOLDOFF SHALL NOT arm the detector; re-arming requires IDLE.

Reset
REQ-014 While reset=1, asynchronously: state=IDLE, timestamp=0, and all outputs 0 (peak_value, peak_time, peak_valid, peak_overflow, busy, event_count); max, max_time, counters and baseline 0.
REQ-015 Reset asserted mid-event SHALL discard the event with no peak_valid; the first sample after release is evaluated from IDLE.

Configuration
REQ-016 Macro PULSE_PEAK_DETECTOR_BASELINE_EN defined: a baseline register SHALL update only in IDLE with bl <= bl + ((input_data - bl) >>> BL_SHIFT), and the compared sample and peak_value SHALL be input_data - bl, saturated.
REQ-017 Macro PULSE_PEAK_DETECTOR_BASELINE_EN undefined: no baseline logic SHALL exist, and the compared sample SHALL be raw input_data.

Verification (defaults, macro undefined unless stated)
REQ-018 Input 0,50,120,300,250,80,0 -> one peak_valid on the edge that samples 80; peak_value=300; peak_time = timestamp of the 300 sample; overflow=0; event_count=1.
REQ-019 Input 0,150,200,200,90 -> peak_value=200, peak_time = timestamp of the first 200.
REQ-020 Constant 500 for 70 cycles -> peak_valid with overflow=1 after 64 samples in ARMED; HOLDOFF 4 cycles; re-arms on the 500 sample taken in IDLE.
REQ-021 Pulse 300 then 50, then 400 within 4 cycles -> second pulse ignored during HOLDOFF; only one event.
REQ-022 Reset pulse while ARMED at max 300 -> no peak_valid; all outputs 0; next pulse of 200 reports 200.
REQ-023 Macro defined, DC input 40 for 200 cycles, then 40+150 -> baseline settles near 40; peak_value approx 150; no event during DC.

Source files
------------

// File: rtl/pulse_peak_detector.sv
// Pulse peak detector: arms on threshold, tracks the maximum sample and its timestamp, emits one event per pulse.
// Optional baseline subtraction: define PULSE_PEAK_DETECTOR_BASELINE_EN.
module pulse_peak_detector #(
  parameter int SIZE_FILTER_DATA = 16,
  parameter int THRESHOLD        = 100,
  parameter int HOLDOFF_LEN      = 4,
  parameter int MAX_LEN          = 64,
  parameter int TS_W             = 32,
  parameter int BL_SHIFT         = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic signed [SIZE_FILTER_DATA-1:0] input_data,
  output logic signed [SIZE_FILTER_DATA-1:0] peak_value,
  output logic        [TS_W-1:0]             peak_time,
  output logic                               peak_valid,
  output logic                               peak_overflow,
  output logic                               busy,
  output logic        [15:0]                 event_count
);
  localparam int W      = SIZE_FILTER_DATA;
  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int HOLD_W = $clog2(HOLDOFF_LEN + 2);
  localparam logic signed [W:0] THR  = (W+1)'(THRESHOLD);
  localparam logic signed [W:0] SMAX = {2'b00, {(W-1){1'b1}}};
  localparam logic signed [W:0] SMIN = {2'b11, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_HOLDOFF} state_t;

  state_t                r_state, w_state_nxt;
  logic        [TS_W-1:0] r_ts;
  logic signed [W-1:0]   r_max;
  logic        [TS_W-1:0] r_max_time;
  logic        [LEN_W-1:0] r_len;
  logic        [HOLD_W-1:0] r_hold;

  logic signed [W-1:0] w_x;
  logic signed [W:0]   w_x_ext, w_max_ext;
  logic                w_ge, w_arm, w_upd, w_close, w_ovf;

  function automatic logic signed [W-1:0] sat(input logic signed [W:0] v);
    if (v > SMAX)      return SMAX[W-1:0];
    else if (v < SMIN) return SMIN[W-1:0];
    else               return v[W-1:0];
  endfunction

`ifdef PULSE_PEAK_DETECTOR_BASELINE_EN
  logic signed [W-1:0] r_bl;
  logic signed [W:0]   w_diff, w_bl_step, w_bl_sum;

  assign w_diff    = {input_data[W-1], input_data} - {r_bl[W-1], r_bl};
  assign w_bl_step = w_diff >>> BL_SHIFT;
  assign w_bl_sum  = {r_bl[W-1], r_bl} + w_bl_step;
  assign w_x       = sat(w_diff);

  // Baseline tracks only between pulses so the pulse itself never drags it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 r_bl <= '0;
    else if (r_state == S_IDLE) r_bl <= sat(w_bl_sum);
  end
`else
  assign w_x = input_data;
`endif

  assign w_x_ext   = {w_x[W-1], w_x};
  assign w_max_ext = {r_max[W-1], r_max};
  assign w_ge      = (w_x_ext >= THR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arm       = 1'b0;
    w_upd       = 1'b0;
    w_close     = 1'b0;
    w_ovf       = 1'b0;
    case (r_state)
      S_IDLE: if (w_ge) begin
        w_state_nxt = S_ARMED;
        w_arm       = 1'b1;
      end
      S_ARMED: begin
        if (!w_ge) begin
          w_close     = 1'b1;
          w_state_nxt = S_HOLDOFF;
        end else if (r_len == LEN_W'(MAX_LEN)) begin
          w_close     = 1'b1;
          w_ovf       = 1'b1;
          w_state_nxt = S_HOLDOFF;
        end else begin
          w_upd = 1'b1;
        end
      end
      S_HOLDOFF: if (r_hold <= HOLD_W'(1)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_ARMED) || (r_state == S_HOLDOFF);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ts          <= '0;
      r_max         <= '0;
      r_max_time    <= '0;
      r_len         <= '0;
      r_hold        <= '0;
      peak_value    <= '0;
      peak_time     <= '0;
      peak_valid    <= 1'b0;
      peak_overflow <= 1'b0;
      event_count   <= '0;
    end else begin
      r_ts       <= r_ts + TS_W'(1);
      peak_valid <= w_close;
      if (w_arm) begin
        r_max      <= w_x;
        r_max_time <= r_ts;
        r_len      <= LEN_W'(1);
      end
      // Strict greater-than keeps the first occurrence on ties.
      if (w_upd) begin
        r_len <= r_len + LEN_W'(1);
        if (w_x_ext > w_max_ext) begin
          r_max      <= w_x;
          r_max_time <= r_ts;
        end
      end
      if (w_close) begin
        peak_value    <= r_max;
        peak_time     <= r_max_time;
        peak_overflow <= w_ovf;
        event_count   <= event_count + 16'd1;
        r_hold        <= HOLD_W'(HOLDOFF_LEN);
      end else if (r_state == S_HOLDOFF && r_hold != '0) begin
        r_hold <= r_hold - HOLD_W'(1);
      end
    end
  end
endmodule
